// File: rtl/guvm_obi_responder.sv
// rtl/guvm_obi_responder.sv - queued OBI memory responder with programmable per-transaction latency
// Stimulus words feed reads in order; responses retire in grant order once their latency expires.
module guvm_obi_responder #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 4,
   parameter int SDEPTH = 8,
   parameter int LAT_W  = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   req_i,
   output logic                   gnt_o,
   input  logic [ADDR_W-1:0]      addr_i,
   input  logic                   we_i,
   input  logic [DATA_W/8-1:0]    be_i,
   input  logic [DATA_W-1:0]      wdata_i,
   output logic                   rvalid_o,
   output logic [DATA_W-1:0]      rdata_o,
   input  logic                   stim_valid_i,
   input  logic [DATA_W-1:0]      stim_data_i,
   output logic                   stim_ready_o,
   input  logic [LAT_W-1:0]       lat_i,
   input  logic                   gnt_stall_i,
   output logic                   wr_valid_o,
   output logic [ADDR_W-1:0]      wr_addr_o,
   output logic [DATA_W-1:0]      wr_data_o,
   output logic [DATA_W/8-1:0]    wr_be_o,
   output logic [15:0]            underrun_cnt_o,
   output logic [$clog2(DEPTH):0] outstanding_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int SW = $clog2(SDEPTH);

   logic [DATA_W-1:0] stim_mem [SDEPTH];
   logic [SW:0]       s_wptr;
   logic [SW:0]       s_rptr;
   logic              s_empty;
   logic              s_full;
   logic              s_push;
   logic              s_pop;

   logic [DATA_W-1:0] p_data [DEPTH];
   logic [LAT_W-1:0]  p_cnt  [DEPTH];
   logic [PW:0]       p_wptr;
   logic [PW:0]       p_rptr;
   logic              p_room;
   logic              head_ready;
   logic [LAT_W-1:0]  new_cnt;
   logic              underrun_hit;

   // The extra pointer bit separates full from empty when the index bits match.
   assign s_empty      = (s_wptr == s_rptr);
   assign s_full       = (s_wptr[SW] != s_rptr[SW]) && (s_wptr[SW-1:0] == s_rptr[SW-1:0]);
   assign stim_ready_o = !s_full;
   assign s_push       = stim_valid_i && !s_full;

   assign outstanding_o = p_wptr - p_rptr;
   assign p_room        = (outstanding_o < (PW+1)'(DEPTH));
   assign head_ready    = (outstanding_o != '0) && (p_cnt[p_rptr[PW-1:0]] == '0);
   assign rvalid_o      = head_ready;
   assign rdata_o       = head_ready ? p_data[p_rptr[PW-1:0]] : '0;

   // Room is judged on the current count only, so a retiring head never frees a slot early.
   assign gnt_o        = !rst_i && req_i && !gnt_stall_i && p_room && (we_i || !s_empty);
   assign s_pop        = gnt_o && !we_i;
   assign new_cnt      = (lat_i == '0) ? '0 : lat_i - LAT_W'(1);
   assign underrun_hit = req_i && !we_i && !gnt_stall_i && s_empty && p_room;

   always_ff @(posedge clk_i) begin
      if (s_push)
         stim_mem[s_wptr[SW-1:0]] <= stim_data_i;
      if (gnt_o)
         p_data[p_wptr[PW-1:0]] <= we_i ? '0 : stim_mem[s_rptr[SW-1:0]];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s_wptr         <= '0;
         s_rptr         <= '0;
         p_wptr         <= '0;
         p_rptr         <= '0;
         for (int i = 0; i < DEPTH; i++)
            p_cnt[i] <= '0;
         wr_valid_o     <= 1'b0;
         wr_addr_o      <= '0;
         wr_data_o      <= '0;
         wr_be_o        <= '0;
         underrun_cnt_o <= '0;
      end else begin
         if (s_push)
            s_wptr <= s_wptr + (SW+1)'(1);
         if (s_pop)
            s_rptr <= s_rptr + (SW+1)'(1);

         // Entries queued behind a slower head saturate at zero and wait their turn.
         for (int i = 0; i < DEPTH; i++)
            if (p_cnt[i] != '0)
               p_cnt[i] <= p_cnt[i] - LAT_W'(1);
         if (gnt_o) begin
            p_cnt[p_wptr[PW-1:0]] <= new_cnt;
            p_wptr                <= p_wptr + (PW+1)'(1);
         end
         if (head_ready)
            p_rptr <= p_rptr + (PW+1)'(1);

         wr_valid_o <= gnt_o && we_i;
         if (gnt_o && we_i) begin
            wr_addr_o <= addr_i;
            wr_data_o <= wdata_i;
            wr_be_o   <= be_i;
         end

         if (underrun_hit && underrun_cnt_o != 16'hFFFF)
            underrun_cnt_o <= underrun_cnt_o + 16'd1;
      end
   end

endmodule

// File: tb/tb_guvm_obi_responder.sv
// tb/tb_guvm_obi_responder.sv - self-checking bench for guvm_obi_responder
// Cycle table for directed latency/ordering cases, a queue model for random traffic, then hand sequences.
module tb_guvm_obi_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req = 1'b0;
   logic        gnt;
   logic [31:0] addr = '0;
   logic        we = 1'b0;
   logic [3:0]  be = '0;
   logic [31:0] wdata = '0;
   logic        rvalid;
   logic [31:0] rdata;
   logic        stim_valid = 1'b0;
   logic [31:0] stim_data = '0;
   logic        stim_ready;
   logic [3:0]  lat = '0;
   logic        stall = 1'b0;
   logic        wr_valid;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_be;
   logic [15:0] underrun;
   logic [2:0]  outstanding;

   int n_chk  = 0;
   int n_fail = 0;

   guvm_obi_responder dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
      .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata),
      .stim_valid_i(stim_valid), .stim_data_i(stim_data), .stim_ready_o(stim_ready),
      .lat_i(lat), .gnt_stall_i(stall), .wr_valid_o(wr_valid), .wr_addr_o(wr_addr),
      .wr_data_o(wr_data), .wr_be_o(wr_be), .underrun_cnt_o(underrun),
      .outstanding_o(outstanding)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      req = 0; we = 0; addr = '0; wdata = '0; be = '0;
      stim_valid = 0; stim_data = '0; lat = '0; stall = 0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      idle_inputs();
      rst = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;
   endtask

   typedef struct {
      logic        sv;
      logic [31:0] sd;
      logic        rq;
      logic        w;
      logic [3:0]  lt;
      logic        e_gnt;
      logic        e_rv;
      logic [31:0] e_rd;
      logic [2:0]  e_out;
   } vec_t;

   function automatic vec_t mk(logic sv, logic [31:0] sd, logic rq, logic w, logic [3:0] lt,
                               logic e_gnt, logic e_rv, logic [31:0] e_rd, logic [2:0] e_out);
      vec_t v;
      v.sv = sv; v.sd = sd; v.rq = rq; v.w = w; v.lt = lt;
      v.e_gnt = e_gnt; v.e_rv = e_rv; v.e_rd = e_rd; v.e_out = e_out;
      return v;
   endfunction

   vec_t tbl [46];

   // Queue model used during random traffic.
   typedef struct { logic [31:0] d; int c; } pend_t;
   typedef struct { logic [31:0] a; logic [31:0] d; logic [3:0] b; } wr_t;
   pend_t       mq[$];
   logic [31:0] sq[$];
   wr_t         wq[$];
   bit          wr_due = 0;
   bit          sb_on = 0;
   bit          granted = 0;
   bit          m_gnt, m_rv, m_acc;
   logic [31:0] m_rd;
   pend_t       m_p;
   wr_t         m_w;

   always @(negedge clk) begin
      if (sb_on) begin
         m_rv  = (mq.size() > 0) && (mq[0].c == 0);
         m_rd  = m_rv ? mq[0].d : 32'h0;
         m_gnt = req && !stall && (mq.size() < 4) && (we || sq.size() > 0);
         m_acc = stim_valid && (sq.size() < 8);
         chk("sb_gnt", {31'b0, gnt}, {31'b0, m_gnt});
         chk("sb_rvalid", {31'b0, rvalid}, {31'b0, m_rv});
         chk("sb_rdata", rdata, m_rd);
         chk("sb_outstanding", {29'b0, outstanding}, mq.size());
         chk("sb_wr_valid", {31'b0, wr_valid}, {31'b0, wr_due});
         if (wr_due && wq.size() > 0) begin
            chk("sb_wr_addr", wr_addr, wq[0].a);
            chk("sb_wr_data", wr_data, wq[0].d);
            chk("sb_wr_be", {28'b0, wr_be}, {28'b0, wq[0].b});
            void'(wq.pop_front());
         end
         wr_due = 0;
         if (m_rv)
            void'(mq.pop_front());
         foreach (mq[i])
            if (mq[i].c > 0)
               mq[i].c = mq[i].c - 1;
         if (m_gnt) begin
            m_p.d = we ? 32'h0 : sq.pop_front();
            m_p.c = (lat == 0) ? 0 : int'(lat) - 1;
            mq.push_back(m_p);
            if (we) begin
               m_w.a = addr; m_w.d = wdata; m_w.b = be;
               wq.push_back(m_w);
               wr_due = 1;
            end
         end
         if (m_acc)
            sq.push_back(stim_data);
         granted = m_gnt;
      end
   end

   initial begin
      // Reset state, with a request held so a grant would be visible.
      @(posedge clk); #1;
      rst = 1; req = 1;
      @(negedge clk);
      chk("rst_gnt", {31'b0, gnt}, 0);
      chk("rst_rvalid", {31'b0, rvalid}, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_outstanding", {29'b0, outstanding}, 0);
      chk("rst_stim_ready", {31'b0, stim_ready}, 1);
      chk("rst_wr_valid", {31'b0, wr_valid}, 0);
      chk("rst_underrun", {16'b0, underrun}, 0);
      do_reset();

      for (int i = 0; i < 46; i++) tbl[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[0] = mk(1, 32'h000FA103, 0, 0, 0, 0, 0, 0, 0);
      tbl[5] = mk(0, 0, 1, 0, 1, 1, 0, 0, 0);
      tbl[6] = mk(0, 0, 0, 0, 0, 0, 1, 32'h000FA103, 1);
      for (int i = 0; i < 4; i++) begin
         tbl[8+i]  = mk(1, 32'hA0 + i, 0, 0, 0, 0, 0, 0, 0);
         tbl[12+i] = mk(0, 0, 1, 0, 3, 1, i == 3, (i == 3) ? 32'hA0 : 32'h0, 3'(i));
      end
      tbl[16] = mk(0, 0, 0, 0, 0, 0, 1, 32'hA1, 3);
      tbl[17] = mk(0, 0, 0, 0, 0, 0, 1, 32'hA2, 2);
      tbl[18] = mk(0, 0, 0, 0, 0, 0, 1, 32'hA3, 1);
      for (int i = 0; i < 5; i++) tbl[20+i] = mk(1, 32'hB0 + i, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) tbl[25+i] = mk(0, 0, 1, 0, 4, 1, 0, 0, 3'(i));
      tbl[29] = mk(0, 0, 1, 0, 4, 0, 1, 32'hB0, 4);
      tbl[30] = mk(0, 0, 1, 0, 4, 1, 1, 32'hB1, 3);
      tbl[31] = mk(0, 0, 0, 0, 0, 0, 1, 32'hB2, 3);
      tbl[32] = mk(0, 0, 0, 0, 0, 0, 1, 32'hB3, 2);
      tbl[33] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
      tbl[34] = mk(0, 0, 0, 0, 0, 0, 1, 32'hB4, 1);
      tbl[36] = mk(1, 32'hC0, 0, 0, 0, 0, 0, 0, 0);
      tbl[37] = mk(1, 32'hC1, 0, 0, 0, 0, 0, 0, 0);
      tbl[38] = mk(0, 0, 1, 0, 5, 1, 0, 0, 0);
      tbl[39] = mk(0, 0, 1, 0, 1, 1, 0, 0, 1);
      for (int i = 40; i < 43; i++) tbl[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 2);
      tbl[43] = mk(0, 0, 0, 0, 0, 0, 1, 32'hC0, 2);
      tbl[44] = mk(0, 0, 0, 0, 0, 0, 1, 32'hC1, 1);

      for (int i = 0; i < 46; i++) begin
         @(posedge clk); #1;
         stim_valid = tbl[i].sv; stim_data = tbl[i].sd;
         req = tbl[i].rq; we = tbl[i].w; lat = tbl[i].lt;
         @(negedge clk);
         chk($sformatf("tbl%0d_gnt", i), {31'b0, gnt}, {31'b0, tbl[i].e_gnt});
         chk($sformatf("tbl%0d_rvalid", i), {31'b0, rvalid}, {31'b0, tbl[i].e_rv});
         chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].e_rd);
         chk($sformatf("tbl%0d_outstanding", i), {29'b0, outstanding}, {29'b0, tbl[i].e_out});
      end

      // Random mixed traffic against the queue model.
      do_reset();
      mq.delete(); sq.delete(); wq.delete(); wr_due = 0; granted = 0;
      sb_on = 1;
      for (int c = 0; c < 400; c++) begin
         @(posedge clk); #1;
         if (c < 360) begin
            if (!req || granted) begin
               req   = ($urandom_range(0, 9) < 7);
               we    = ($urandom_range(0, 9) < 3);
               addr  = $urandom;
               wdata = $urandom;
               be    = 4'($urandom_range(0, 15));
            end
            stall      = ($urandom_range(0, 9) < 2);
            lat        = 4'($urandom_range(0, 6));
            stim_valid = ($urandom_range(0, 9) < 4);
            stim_data  = $urandom;
         end else begin
            idle_inputs();
         end
      end
      @(negedge clk);
      sb_on = 0;
      chk("drain_outstanding", {29'b0, outstanding}, 0);

      // Underrun: seven empty-queue request cycles, word pushed in the last one.
      do_reset();
      for (int i = 0; i < 7; i++) begin
         @(posedge clk); #1;
         req = 1; we = 0; lat = 1; stim_valid = (i == 6); stim_data = 32'h1;
         @(negedge clk);
         chk($sformatf("underrun_gnt_low%0d", i), {31'b0, gnt}, 0);
      end
      @(posedge clk); #1 stim_valid = 0;
      @(negedge clk);
      chk("underrun_gnt_after_push", {31'b0, gnt}, 1);
      chk("underrun_cnt", {16'b0, underrun}, 7);
      @(posedge clk); #1 req = 0;
      @(negedge clk);
      chk("underrun_rvalid", {31'b0, rvalid}, 1);
      chk("underrun_rdata", rdata, 32'h1);

      // Write capture with latency 2.
      @(posedge clk); #1;
      req = 1; we = 1; addr = 32'h100; wdata = 32'hDEADBEEF; be = 4'hF; lat = 2;
      @(negedge clk);
      chk("wr_gnt", {31'b0, gnt}, 1);
      @(posedge clk); #1 idle_inputs();
      @(negedge clk);
      chk("wr_valid_k1", {31'b0, wr_valid}, 1);
      chk("wr_addr", wr_addr, 32'h100);
      chk("wr_data", wr_data, 32'hDEADBEEF);
      chk("wr_be", {28'b0, wr_be}, 32'hF);
      chk("wr_rvalid_k1", {31'b0, rvalid}, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("wr_rvalid_k2", {31'b0, rvalid}, 1);
      chk("wr_rdata_k2", rdata, 0);
      chk("wr_valid_k2", {31'b0, wr_valid}, 0);

      // Reset with three reads in flight.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1 stim_valid = 1; stim_data = 32'h50 + i;
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1 stim_valid = 0; req = 1; we = 0; lat = 8;
         @(negedge clk);
         chk($sformatf("inflight_gnt%0d", i), {31'b0, gnt}, 1);
      end
      @(posedge clk); #1 stall = 1;
      @(negedge clk);
      chk("stall_gnt", {31'b0, gnt}, 0);
      chk("stall_outstanding", {29'b0, outstanding}, 3);
      chk("stall_underrun", {16'b0, underrun}, 7);
      @(posedge clk); #2 rst = 1;
      #1;
      chk("midrst_gnt", {31'b0, gnt}, 0);
      chk("midrst_rvalid", {31'b0, rvalid}, 0);
      chk("midrst_rdata", rdata, 0);
      chk("midrst_outstanding", {29'b0, outstanding}, 0);
      chk("midrst_stim_ready", {31'b0, stim_ready}, 1);
      chk("midrst_underrun", {16'b0, underrun}, 0);
      chk("midrst_wr_valid", {31'b0, wr_valid}, 0);
      @(posedge clk); #1 rst = 0; stall = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk($sformatf("postrst_rvalid%0d", i), {31'b0, rvalid}, 0);
         chk($sformatf("postrst_gnt%0d", i), {31'b0, gnt}, 0);
         @(posedge clk); #1;
      end
      idle_inputs();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
